// File: rtl/nand_block_erase_engine.sv
// NAND block-erase sequencer: 60h, three row bytes, D0h, wait R/B#, 70h, status read.
// Pins are registered from the current state, so they trail the FSM by one cycle.
module nand_block_erase_engine #(
    parameter int unsigned TWP_CYC     = 2,
    parameter int unsigned TWH_CYC     = 2,
    parameter int unsigned TWB_CYC     = 8,
    parameter int unsigned TWHR_CYC    = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_erase_page,
    input  logic [23:0] erase_addr_row,
    output logic        end_erase_page,
    output logic        erase_fail,
    output logic        erase_timeout,
    output logic        busy,
    output logic        nf_ce_n,
    output logic        nf_cle,
    output logic        nf_ale,
    output logic        nf_we_n,
    output logic        nf_re_n,
    output logic [7:0]  nf_dq_out,
    output logic        nf_dq_oe,
    input  logic [7:0]  nf_dq_in,
    input  logic        nf_rb_n
);
    localparam int unsigned BYTE_LEN = 1 + TWP_CYC + TWH_CYC;
    localparam int unsigned M0   = (TWB_CYC > TWHR_CYC) ? TWB_CYC : TWHR_CYC;
    localparam int unsigned M1   = (M0 > BYTE_LEN) ? M0 : BYTE_LEN;
    localparam int unsigned MAXP = (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
    localparam int unsigned CW   = $clog2(MAXP) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_WAIT_WB, S_WAIT_RB,
        S_STAT_CMD, S_WAIT_WHR, S_READ, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      addr_idx, addr_nxt;
    logic [23:0]     row_q;
    logic            en_q, rb_meta, rb_sync;
    logic            load_c, capture_c, timeout_c, we_low_c, byte_done_c;
    logic            ce_c, cle_c, ale_c, we_c, re_c, oe_c;
    logic [7:0]      dq_c;
    logic            unused_dq;

    assign unused_dq = ^nf_dq_in[7:1];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state, counter control and pin values for the current state
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CW'(1);
        addr_nxt    = addr_idx;
        load_c      = 1'b0;
        capture_c   = 1'b0;
        timeout_c   = 1'b0;
        ce_c        = 1'b0;
        cle_c       = 1'b0;
        ale_c       = 1'b0;
        we_c        = 1'b1;
        re_c        = 1'b1;
        oe_c        = 1'b0;
        dq_c        = 8'h00;
        we_low_c    = (cnt != CW'(0)) && (cnt <= CW'(TWP_CYC));
        byte_done_c = (cnt == CW'(BYTE_LEN - 1));
        case (state)
            S_IDLE: begin
                ce_c    = 1'b1;
                cnt_nxt = CW'(0);
                if (en_erase_page && !en_q) begin
                    state_nxt = S_CMD1;
                    load_c    = 1'b1;
                end
            end
            S_CMD1: begin
                cle_c = 1'b1; oe_c = 1'b1; dq_c = 8'h60; we_c = !we_low_c;
                if (byte_done_c) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = CW'(0);
                    addr_nxt  = 2'd0;
                end
            end
            S_ADDR: begin
                ale_c = 1'b1; oe_c = 1'b1; we_c = !we_low_c;
                case (addr_idx)
                    2'd0:    dq_c = row_q[7:0];
                    2'd1:    dq_c = row_q[15:8];
                    default: dq_c = row_q[23:16];
                endcase
                if (byte_done_c) begin
                    cnt_nxt = CW'(0);
                    if (addr_idx == 2'd2) state_nxt = S_CMD2;
                    else                  addr_nxt  = addr_idx + 2'd1;
                end
            end
            S_CMD2: begin
                cle_c = 1'b1; oe_c = 1'b1; dq_c = 8'hD0; we_c = !we_low_c;
                if (byte_done_c) begin
                    state_nxt = S_WAIT_WB;
                    cnt_nxt   = CW'(0);
                end
            end
            S_WAIT_WB: begin
                if (cnt == CW'(TWB_CYC - 1)) begin
                    state_nxt = S_WAIT_RB;
                    cnt_nxt   = CW'(0);
                end
            end
            S_WAIT_RB: begin
                if (rb_sync) begin
                    state_nxt = S_STAT_CMD;
                    cnt_nxt   = CW'(0);
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nxt = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_STAT_CMD: begin
                cle_c = 1'b1; oe_c = 1'b1; dq_c = 8'h70; we_c = !we_low_c;
                if (byte_done_c) begin
                    state_nxt = S_WAIT_WHR;
                    cnt_nxt   = CW'(0);
                end
            end
            S_WAIT_WHR: begin
                if (cnt == CW'(TWHR_CYC - 1)) begin
                    state_nxt = S_READ;
                    cnt_nxt   = CW'(0);
                end
            end
            S_READ: begin
                re_c = !(cnt < CW'(TWP_CYC));
                // registered RE# is still in its last low cycle when cnt reaches TWP
                if (cnt == CW'(TWP_CYC)) capture_c = 1'b1;
                if (cnt == CW'(TWP_CYC + TWH_CYC - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                ce_c      = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = CW'(0);
            end
            default: begin
                ce_c      = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = CW'(0);
            end
        endcase
    end

    // datapath, flags and registered pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            addr_idx       <= 2'd0;
            row_q          <= 24'h0;
            en_q           <= 1'b0;
            rb_meta        <= 1'b0;
            rb_sync        <= 1'b0;
            end_erase_page <= 1'b0;
            erase_fail     <= 1'b0;
            erase_timeout  <= 1'b0;
            busy           <= 1'b0;
            nf_ce_n        <= 1'b1;
            nf_cle         <= 1'b0;
            nf_ale         <= 1'b0;
            nf_we_n        <= 1'b1;
            nf_re_n        <= 1'b1;
            nf_dq_out      <= 8'h00;
            nf_dq_oe       <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            addr_idx       <= addr_nxt;
            en_q           <= en_erase_page;
            rb_meta        <= nf_rb_n;
            rb_sync        <= rb_meta;
            end_erase_page <= (state == S_DONE);
            busy           <= (state != S_IDLE) || load_c;
            if (load_c) begin
                row_q         <= erase_addr_row;
                erase_fail    <= 1'b0;
                erase_timeout <= 1'b0;
            end else if (timeout_c) begin
                erase_fail    <= 1'b1;
                erase_timeout <= 1'b1;
            end else if (capture_c) begin
                erase_fail    <= nf_dq_in[0];
            end
            nf_ce_n   <= ce_c;
            nf_cle    <= cle_c;
            nf_ale    <= ale_c;
            nf_we_n   <= we_c;
            nf_re_n   <= re_c;
            nf_dq_out <= dq_c;
            nf_dq_oe  <= oe_c;
        end
    end
endmodule

// File: tb/tb_nand_block_erase_engine.sv
// Directed bench for nand_block_erase_engine: byte sequence, pin timing, status,
// timeout, mid-operation reset and start-edge handling.
module tb_nand_block_erase_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_erase_page;
    logic [23:0] erase_addr_row;
    logic        end_erase_page, erase_fail, erase_timeout, busy;
    logic        nf_ce_n, nf_cle, nf_ale, nf_we_n, nf_re_n, nf_dq_oe;
    logic [7:0]  nf_dq_out, nf_dq_in;
    logic        nf_rb_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_cyc = 0;
    int end_cnt, end_cyc, re_low;
    logic busy_at_end;
    logic prev_we = 1'b1;
    int fall_q[$];
    int rise_q[$];
    logic [9:0] byte_q[$];

    nand_block_erase_engine #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .en_erase_page(en_erase_page), .erase_addr_row(erase_addr_row),
        .end_erase_page(end_erase_page), .erase_fail(erase_fail), .erase_timeout(erase_timeout),
        .busy(busy), .nf_ce_n(nf_ce_n), .nf_cle(nf_cle), .nf_ale(nf_ale), .nf_we_n(nf_we_n),
        .nf_re_n(nf_re_n), .nf_dq_out(nf_dq_out), .nf_dq_oe(nf_dq_oe), .nf_dq_in(nf_dq_in),
        .nf_rb_n(nf_rb_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pin monitor: samples on the falling edge, cyc names the preceding rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_we && !nf_we_n) fall_q.push_back(cyc);
            if (!prev_we && nf_we_n) begin
                rise_q.push_back(cyc);
                byte_q.push_back({nf_cle, nf_ale, nf_dq_out});
            end
            if (!nf_re_n) re_low++;
            if (end_erase_page) begin
                end_cnt++;
                end_cyc     = cyc;
                busy_at_end = busy;
            end
        end
        prev_we = nf_we_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_erase(input logic [23:0] row, input logic [7:0] st, input int rb_low);
        fall_q.delete();
        rise_q.delete();
        byte_q.delete();
        end_cnt        = 0;
        re_low         = 0;
        nf_dq_in       = st;
        nf_rb_n        = (rb_low == 0);
        erase_addr_row = row;
        step();
        en_erase_page  = 1'b1;
        s_cyc          = cyc + 1;
    endtask

    task automatic wait_end(input int rb_low);
        for (int i = 0; i < 2000 && end_cnt == 0; i++) begin
            step();
            if (rb_low >= 0 && cyc - s_cyc >= rb_low) nf_rb_n = 1'b1;
        end
        chk("end_seen", 32'(end_cnt != 0), 32'd1);
    endtask

    task automatic check_bytes(input logic [23:0] row, input bit with_stat);
        logic [9:0] exp_b [6];
        int n;
        n = with_stat ? 6 : 5;
        exp_b[0] = {2'b10, 8'h60};
        exp_b[1] = {2'b01, row[7:0]};
        exp_b[2] = {2'b01, row[15:8]};
        exp_b[3] = {2'b01, row[23:16]};
        exp_b[4] = {2'b10, 8'hD0};
        exp_b[5] = {2'b10, 8'h70};
        chk("byte_count", 32'(byte_q.size()), 32'(n));
        for (int i = 0; i < n && i < byte_q.size(); i++)
            chk($sformatf("byte%0d", i), 32'(byte_q[i]), 32'(exp_b[i]));
        chk("we_fall0", (fall_q.size() > 0) ? 32'(fall_q[0] - s_cyc) : 32'hFFFF_FFFF, 32'd2);
        chk("we_low_w", (rise_q.size() > 0 && fall_q.size() > 0) ? 32'(rise_q[0] - fall_q[0]) : 32'hFFFF_FFFF, 32'd2);
        chk("we_high_w", (rise_q.size() > 0 && fall_q.size() > 1) ? 32'(fall_q[1] - rise_q[0]) : 32'hFFFF_FFFF, 32'd3);
        chk("we_rise_d0", (rise_q.size() > 4) ? 32'(rise_q[4] - s_cyc) : 32'hFFFF_FFFF, 32'd24);
    endtask

    initial begin
        rst = 1'b1;
        en_erase_page  = 1'b0;
        erase_addr_row = 24'h0;
        nf_dq_in = 8'h00;
        nf_rb_n  = 1'b1;
        repeat (3) step();
        chk("rst_pins", {22'h0, nf_ce_n, nf_we_n, nf_re_n, nf_cle, nf_ale, nf_dq_oe,
                         end_erase_page, busy, erase_fail, erase_timeout}, 32'b11_1000_0000);
        chk("rst_dq", 32'(nf_dq_out), 32'h0);
        rst = 1'b0;
        repeat (2) step();

        // 1: normal erase, status pass
        start_erase(24'h012380, 8'hE0, 50);
        wait_end(50);
        en_erase_page = 1'b0;
        check_bytes(24'h012380, 1'b1);
        chk("t1_end_cyc", 32'(end_cyc - s_cyc), 32'd71);
        chk("t1_busy_at_end", 32'(busy_at_end), 32'd1);
        chk("t1_re_low", 32'(re_low), 32'd2);
        repeat (3) step();
        chk("t1_end_cnt", 32'(end_cnt), 32'd1);
        chk("t1_flags", {30'h0, erase_fail, erase_timeout}, 32'b00);
        chk("t1_idle", {30'h0, busy, nf_ce_n}, 32'b01);

        // 2: status fail bit set; flags persist while idle
        start_erase(24'h012380, 8'hE1, 50);
        wait_end(50);
        en_erase_page = 1'b0;
        check_bytes(24'h012380, 1'b1);
        repeat (10) step();
        chk("t2_flags_hold", {30'h0, erase_fail, erase_timeout}, 32'b10);

        // 3: R/B# stuck low -> timeout, no status read
        start_erase(24'h00FF00, 8'hE0, -1);
        step();
        chk("t3_flags_clear", {30'h0, erase_fail, erase_timeout}, 32'b00);
        wait_end(-1);
        en_erase_page = 1'b0;
        check_bytes(24'h00FF00, 1'b0);
        chk("t3_end_cyc", 32'(end_cyc - s_cyc), 32'd134);
        chk("t3_re_low", 32'(re_low), 32'd0);
        chk("t3_flags", {30'h0, erase_fail, erase_timeout}, 32'b11);
        repeat (3) step();

        // 4: reset during second address byte, then a clean run
        start_erase(24'h456789, 8'hE0, 0);
        while (cyc < s_cyc + 12) step();
        chk("t4_in_addr", 32'(nf_ale), 32'd1);
        #1;
        rst = 1'b1;
        en_erase_page = 1'b0;
        #1;
        chk("t4_rst_pins", {24'h0, nf_ce_n, nf_we_n, nf_re_n, nf_cle, nf_ale, nf_dq_oe, busy, end_erase_page},
            32'b1110_0000);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        start_erase(24'hA5C33C, 8'hE0, 0);
        wait_end(0);
        en_erase_page = 1'b0;
        check_bytes(24'hA5C33C, 1'b1);
        chk("t4_flags", {30'h0, erase_fail, erase_timeout}, 32'b00);
        repeat (3) step();

        // 5: level held after end must not restart; a fresh edge does
        start_erase(24'h000001, 8'hE0, 0);
        wait_end(0);
        step();
        chk("t5_no_restart", {30'h0, busy, nf_ce_n}, 32'b01);
        en_erase_page = 1'b0;
        step();
        en_erase_page = 1'b1;
        step();
        chk("t5_restart_busy", 32'(busy), 32'd1);
        end_cnt = 0;
        wait_end(0);
        en_erase_page = 1'b0;
        repeat (3) step();

        // 6: R/B# high throughout
        start_erase(24'hFEDCBA, 8'hE0, 0);
        wait_end(0);
        en_erase_page = 1'b0;
        check_bytes(24'hFEDCBA, 1'b1);
        chk("t6_end_cyc", 32'(end_cyc - s_cyc), 32'd52);
        chk("t6_re_low", 32'(re_low), 32'd2);
        chk("t6_flags", {30'h0, erase_fail, erase_timeout}, 32'b00);
        repeat (3) step();
        chk("t6_end_cnt", 32'(end_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
